// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared constants and state type for the sample queue and band FIRs
package eq_pkg;

    localparam int DEF_DEPTH    = 1024;
    localparam int DEF_READ_LEN = 1021;
    localparam int DEF_WIDTH    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        READ = 2'd2
    } cq_state_e;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/smpl_cqueue_if.sv
// rtl/smpl_cqueue_if.sv - sample-in / replay-out signal bundle for smpl_cqueue
interface smpl_cqueue_if
    import eq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             wrt_smpl;
    logic [WIDTH-1:0] lft_smpl;
    logic [WIDTH-1:0] rght_smpl;
    logic [WIDTH-1:0] lft_out;
    logic [WIDTH-1:0] rght_out;
    logic             sequencing;
    logic             ovr;

    modport master (
        output wrt_smpl, lft_smpl, rght_smpl,
        input  lft_out, rght_out, sequencing, ovr
    );

    modport slave (
        input  wrt_smpl, lft_smpl, rght_smpl,
        output lft_out, rght_out, sequencing, ovr
    );

endinterface

// File: rtl/dp_ram_sync.sv
// rtl/dp_ram_sync.sv - simple dual-port RAM, one write port, one registered read port
module dp_ram_sync #(
    parameter  int DEPTH = 1024,
    parameter  int DW    = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_d;
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds between reads so the consumer sees a stable value.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/smpl_cqueue.sv
// rtl/smpl_cqueue.sv - stereo circular sample queue replaying the last READ_LEN samples per write
module smpl_cqueue
    import eq_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int READ_LEN = DEF_READ_LEN,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    smpl_cqueue_if.slave bus
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] FULL_CNT = AW'(READ_LEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(READ_LEN - 1);

    if (!is_pow2(DEPTH) || READ_LEN < 1 || READ_LEN > DEPTH - 1) begin : g_bad_params
        $error("smpl_cqueue: DEPTH must be a power of 2 and 1 <= READ_LEN <= DEPTH-1");
    end

    cq_state_e     state_d, state_q;
    logic [AW-1:0] new_ptr_d, new_ptr_q;
    logic [AW-1:0] old_ptr_d, old_ptr_q;
    logic [AW-1:0] rd_ptr_d, rd_ptr_q;
    logic [AW-1:0] fill_d, fill_q;
    logic [AW-1:0] idx_d, idx_q;
    logic          seq_d, seq_q;
    logic          ovr_d, ovr_q;
    logic [AW-1:0] fill_inc;
    logic          ram_we;
    logic          ram_re;
    logic [2*WIDTH-1:0] ram_rd_data;

    always_comb begin
        state_d   = state_q;
        new_ptr_d = new_ptr_q;
        old_ptr_d = old_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fill_d    = fill_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        ovr_d     = ovr_q | (bus.wrt_smpl && (state_q != IDLE));
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        fill_inc  = (fill_q == FULL_CNT) ? fill_q : fill_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.wrt_smpl) begin
                    ram_we    = 1'b1;
                    new_ptr_d = new_ptr_q + 1'b1;
                    fill_d    = fill_inc;
                    if (fill_inc == FULL_CNT) begin
                        state_d  = LEAD;
                        rd_ptr_d = old_ptr_q;
                        seq_d    = 1'b1;
                    end
                end
            end
            LEAD: begin
                ram_re   = 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
                idx_d    = '0;
                state_d  = READ;
            end
            READ: begin
                // The final data word is already in the read register, so no
                // read is issued on the last cycle and the outputs hold it.
                if (idx_q == LAST_IDX) begin
                    state_d   = IDLE;
                    seq_d     = 1'b0;
                    old_ptr_d = old_ptr_q + 1'b1;
                end else begin
                    ram_re   = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    idx_d    = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                seq_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            new_ptr_q <= '0;
            old_ptr_q <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            idx_q     <= '0;
            seq_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            new_ptr_q <= new_ptr_d;
            old_ptr_q <= old_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
            ovr_q     <= ovr_d;
        end
    end

    dp_ram_sync #(
        .DEPTH (DEPTH),
        .DW    (2 * WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ram_we),
        .wr_addr (new_ptr_q),
        .wr_data ({bus.lft_smpl, bus.rght_smpl}),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    assign bus.lft_out    = ram_rd_data[2*WIDTH-1:WIDTH];
    assign bus.rght_out   = ram_rd_data[WIDTH-1:0];
    assign bus.sequencing = seq_q;
    assign bus.ovr        = ovr_q;

endmodule

// File: tb/tb_smpl_cqueue.sv
// tb/tb_smpl_cqueue.sv - randomized self-checking bench for smpl_cqueue
module tb_smpl_cqueue;
    import eq_pkg::*;

    localparam int BIG_RL = 1021;
    localparam int SML_RL = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    smpl_cqueue_if #(.WIDTH(16)) bb ();
    smpl_cqueue_if #(.WIDTH(16)) sb ();

    smpl_cqueue #(.DEPTH(1024), .READ_LEN(BIG_RL), .WIDTH(16)) dut_big (
        .clk(clk), .rst_n(rst_n), .bus(bb)
    );
    smpl_cqueue #(.DEPTH(8), .READ_LEN(SML_RL), .WIDTH(16)) dut_sml (
        .clk(clk), .rst_n(rst_n), .bus(sb)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference: every accepted sample since reset, per instance; a burst is the tail.
    logic [15:0] mq_l [2][$];
    logic [15:0] mq_r [2][$];

    logic [15:0] cap_l [0:1100];
    logic [15:0] cap_r [0:1100];
    logic        cap_seq [0:1100];
    logic        cap_ovr [0:1100];
    int          cap_len;
    int          bad_idx;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic w, input logic [15:0] l, input logic [15:0] r);
        if (sel == 0) begin
            bb.wrt_smpl = w; bb.lft_smpl = l; bb.rght_smpl = r;
        end else begin
            sb.wrt_smpl = w; sb.lft_smpl = l; sb.rght_smpl = r;
        end
    endtask

    task automatic observe(input int sel, output logic s, output logic [15:0] l,
                           output logic [15:0] r, output logic o);
        if (sel == 0) begin
            s = bb.sequencing; l = bb.lft_out; r = bb.rght_out; o = bb.ovr;
        end else begin
            s = sb.sequencing; l = sb.lft_out; r = sb.rght_out; o = sb.ovr;
        end
    endtask

    task automatic wr(input int sel, input logic [15:0] l, input logic [15:0] r);
        drive(sel, 1'b1, l, r);
        step();
        drive(sel, 1'b0, 16'h0, 16'h0);
        mq_l[sel].push_back(l);
        mq_r[sel].push_back(r);
    endtask

    // Record cycles T+1 .. T+rl+1+tail after a write; optionally inject 0x7FFF in cycle T+inj_c.
    task automatic capture(input int sel, input int inj_c, input int tail);
        int rl = (sel == 0) ? BIG_RL : SML_RL;
        bit run = 1'b1;
        cap_len = 0;
        for (int c = 1; c <= rl + 1 + tail; c++) begin
            observe(sel, cap_seq[c], cap_l[c], cap_r[c], cap_ovr[c]);
            if (run && cap_seq[c]) cap_len++;
            else run = 1'b0;
            if (c == inj_c) drive(sel, 1'b1, 16'h7FFF, 16'h7FFF);
            else drive(sel, 1'b0, 16'h0, 16'h0);
            step();
        end
        drive(sel, 1'b0, 16'h0, 16'h0);
    endtask

    function automatic int window_bad(input int sel);
        int rl = (sel == 0) ? BIG_RL : SML_RL;
        int n = mq_l[sel].size();
        int bad = 0;
        bad_idx = -1;
        for (int i = 0; i < rl; i++) begin
            if (cap_l[i+2] !== mq_l[sel][n-rl+i] || cap_r[i+2] !== mq_r[sel][n-rl+i]) begin
                bad++;
                if (bad_idx < 0) bad_idx = i;
            end
        end
        return bad;
    endfunction

    function automatic logic [15:0] rnd16();
        logic [15:0] v = 16'($urandom);
        if (v == 16'h0000 || v == 16'h7FFF) v = 16'h1234;
        return v;
    endfunction

    task automatic test_reset();
        logic s, o;
        logic [15:0] l, r;
        rst_n = 1'b0;
        drive(0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 16'h0, 16'h0);
        repeat (3) step();
        observe(0, s, l, r, o);
        tests_run++; if (s !== 1'b0) begin tests_failed++; $display("FAIL reset_seq: got %b expected 0", s); end
        tests_run++; if (l !== 16'h0) begin tests_failed++; $display("FAIL reset_lft: got %h expected 0000", l); end
        tests_run++; if (r !== 16'h0) begin tests_failed++; $display("FAIL reset_rght: got %h expected 0000", r); end
        tests_run++; if (o !== 1'b0) begin tests_failed++; $display("FAIL reset_ovr: got %b expected 0", o); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fill();
        logic s, o;
        logic [15:0] l, r;
        int viol = 0;
        for (int k = 1; k <= BIG_RL - 1; k++) begin
            wr(0, 16'(k), 16'(-k));
            observe(0, s, l, r, o);
            if (s !== 1'b0 || l !== 16'h0 || r !== 16'h0) viol++;
            repeat ($urandom_range(0, 3)) begin
                step();
                observe(0, s, l, r, o);
                if (s !== 1'b0 || l !== 16'h0 || r !== 16'h0) viol++;
            end
        end
        tests_run++; if (viol !== 0) begin tests_failed++; $display("FAIL fill_quiet: got %0d active cycles expected 0", viol); end
        tests_run++; if (o !== 1'b0) begin tests_failed++; $display("FAIL fill_ovr: got %b expected 0", o); end
    endtask

    task automatic test_first_burst();
        int b;
        wr(0, 16'(BIG_RL), 16'(-BIG_RL));
        capture(0, 0, 2);
        b = window_bad(0);
        tests_run++; if (cap_len !== BIG_RL + 1) begin tests_failed++; $display("FAIL first_len: got %0d expected %0d", cap_len, BIG_RL + 1); end
        tests_run++; if (b !== 0) begin tests_failed++; $display("FAIL first_data: got %0d bad words (first at %0d) expected 0", b, bad_idx); end
        tests_run++; if (cap_l[1] !== 16'h0) begin tests_failed++; $display("FAIL first_lead_stale: got %h expected 0000", cap_l[1]); end
        tests_run++; if (cap_l[2] !== 16'd1 || cap_r[2] !== 16'hFFFF) begin tests_failed++; $display("FAIL first_oldest: got %h/%h expected 0001/ffff", cap_l[2], cap_r[2]); end
        tests_run++; if (cap_l[BIG_RL+1] !== 16'(BIG_RL)) begin tests_failed++; $display("FAIL first_newest: got %0d expected %0d", cap_l[BIG_RL+1], BIG_RL); end
        tests_run++; if (cap_seq[BIG_RL+2] !== 1'b0) begin tests_failed++; $display("FAIL first_seq_drop: got %b expected 0", cap_seq[BIG_RL+2]); end
        tests_run++; if (cap_l[BIG_RL+3] !== 16'(BIG_RL)) begin tests_failed++; $display("FAIL first_hold: got %0d expected %0d", cap_l[BIG_RL+3], BIG_RL); end
    endtask

    task automatic test_sliding();
        int b;
        for (int n = 0; n < 4; n++) begin
            if (n == 0) wr(0, 16'd1022, 16'(-1022));
            else wr(0, rnd16(), rnd16());
            capture(0, 0, 1);
            b = window_bad(0);
            tests_run++; if (cap_len !== BIG_RL + 1) begin tests_failed++; $display("FAIL slide%0d_len: got %0d expected %0d", n, cap_len, BIG_RL + 1); end
            tests_run++; if (b !== 0) begin tests_failed++; $display("FAIL slide%0d_data: got %0d bad words (first at %0d) expected 0", n, b, bad_idx); end
            if (n == 0) begin
                tests_run++; if (cap_l[2] !== 16'd2) begin tests_failed++; $display("FAIL slide_oldest: got %0d expected 2", cap_l[2]); end
            end
        end
    endtask

    task automatic test_overrun();
        int b;
        int hits = 0;
        logic s, o;
        logic [15:0] l, r;
        logic [15:0] v;
        wr(0, rnd16(), rnd16());
        capture(0, 100, 2);
        b = window_bad(0);
        tests_run++; if (cap_len !== BIG_RL + 1) begin tests_failed++; $display("FAIL ovr_len: got %0d expected %0d", cap_len, BIG_RL + 1); end
        tests_run++; if (b !== 0) begin tests_failed++; $display("FAIL ovr_data: got %0d bad words (first at %0d) expected 0", b, bad_idx); end
        tests_run++; if (cap_ovr[100] !== 1'b0) begin tests_failed++; $display("FAIL ovr_early: got %b expected 0", cap_ovr[100]); end
        tests_run++; if (cap_ovr[101] !== 1'b1) begin tests_failed++; $display("FAIL ovr_set: got %b expected 1", cap_ovr[101]); end
        tests_run++; if (cap_ovr[BIG_RL+3] !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky: got %b expected 1", cap_ovr[BIG_RL+3]); end

        wr(0, rnd16(), rnd16());
        capture(0, 0, 2);
        for (int c = 2; c <= BIG_RL + 1; c++) if (cap_l[c] === 16'h7FFF || cap_r[c] === 16'h7FFF) hits++;
        b = window_bad(0);
        tests_run++; if (hits !== 0) begin tests_failed++; $display("FAIL ovr_dropped: got %0d 7fff words expected 0", hits); end
        tests_run++; if (b !== 0) begin tests_failed++; $display("FAIL ovr_next_data: got %0d bad words expected 0", b); end

        // Write on the last READ cycle is dropped; the first IDLE cycle accepts.
        wr(0, rnd16(), rnd16());
        capture(0, BIG_RL + 1, 0);
        observe(0, s, l, r, o);
        tests_run++; if (s !== 1'b0) begin tests_failed++; $display("FAIL edge_idle_seq: got %b expected 0", s); end
        v = rnd16();
        wr(0, v, rnd16());
        capture(0, 0, 2);
        b = window_bad(0);
        tests_run++; if (cap_len !== BIG_RL + 1) begin tests_failed++; $display("FAIL edge_len: got %0d expected %0d", cap_len, BIG_RL + 1); end
        tests_run++; if (b !== 0) begin tests_failed++; $display("FAIL edge_data: got %0d bad words (first at %0d) expected 0", b, bad_idx); end
        tests_run++; if (cap_l[BIG_RL+1] !== v) begin tests_failed++; $display("FAIL edge_newest: got %h expected %h", cap_l[BIG_RL+1], v); end
    endtask

    task automatic test_reset_mid();
        logic s, o;
        logic [15:0] l, r;
        int viol = 0;
        int b;
        wr(0, rnd16(), rnd16());
        repeat (499) step();
        observe(0, s, l, r, o);
        tests_run++; if (s !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_seq: got %b expected 1", s); end
        #2 rst_n = 1'b0;
        #1 observe(0, s, l, r, o);
        tests_run++; if (s !== 1'b0) begin tests_failed++; $display("FAIL mid_seq: got %b expected 0", s); end
        tests_run++; if (l !== 16'h0 || r !== 16'h0) begin tests_failed++; $display("FAIL mid_out: got %h/%h expected 0000/0000", l, r); end
        tests_run++; if (o !== 1'b0) begin tests_failed++; $display("FAIL mid_ovr: got %b expected 0", o); end
        repeat (2) step();
        #2 rst_n = 1'b1;
        step();
        mq_l[0].delete();
        mq_r[0].delete();
        for (int k = 1; k <= BIG_RL - 1; k++) begin
            wr(0, rnd16(), rnd16());
            observe(0, s, l, r, o);
            if (s !== 1'b0) viol++;
        end
        tests_run++; if (viol !== 0) begin tests_failed++; $display("FAIL mid_refill_quiet: got %0d active cycles expected 0", viol); end
        wr(0, rnd16(), rnd16());
        capture(0, 0, 2);
        b = window_bad(0);
        tests_run++; if (cap_len !== BIG_RL + 1) begin tests_failed++; $display("FAIL mid_burst_len: got %0d expected %0d", cap_len, BIG_RL + 1); end
        tests_run++; if (b !== 0) begin tests_failed++; $display("FAIL mid_burst_data: got %0d bad words (first at %0d) expected 0", b, bad_idx); end
    endtask

    task automatic test_small_wrap();
        int b;
        int exp_len;
        for (int w = 1; w <= 20; w++) begin
            wr(1, rnd16(), rnd16());
            capture(1, 0, 2);
            exp_len = (mq_l[1].size() >= SML_RL) ? SML_RL + 1 : 0;
            tests_run++; if (cap_len !== exp_len) begin tests_failed++; $display("FAIL small%0d_len: got %0d expected %0d", w, cap_len, exp_len); end
            if (mq_l[1].size() >= SML_RL) begin
                b = window_bad(1);
                tests_run++; if (b !== 0) begin tests_failed++; $display("FAIL small%0d_data: got %0d bad words (first at %0d) expected 0", w, b, bad_idx); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_first_burst();
        test_sliding();
        test_overrun();
        test_reset_mid();
        test_small_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/smpl_cqueue.md
Name: smpl_cqueue

Overview:
- Stereo circular sample queue that sits directly upstream of each band FIR filter.
- Stores incoming 16-bit left/right audio samples.
- On every new sample (once primed) it replays the most recent READ_LEN samples, oldest to newest, one per clock.
- `sequencing` frames each replay burst; the FIR uses it to clear its accumulator and step its coefficient ROM pointer.

Parameters:
- DEPTH, 1024, storage entries per channel; must be a power of 2.
- READ_LEN, 1021, samples replayed per burst (equals FIR tap count); 1 ≤ READ_LEN ≤ DEPTH-1.
- WIDTH, 16, sample width in bits (signed two's complement).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wrt_smpl  in  1  one-cycle strobe: lft_smpl/rght_smpl valid this cycle.
- lft_smpl  in  WIDTH  left sample in.
- rght_smpl  in  WIDTH  right sample in.
- lft_out  out  WIDTH  replayed left sample to FIR lft_in.
- rght_out  out  WIDTH  replayed right sample to FIR rght_in.
- sequencing  out  1  high for the whole replay burst (lead-in cycle + READ_LEN data cycles).
- ovr  out  1  sticky overrun flag: wrt_smpl arrived while a burst was in progress.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: new_ptr=0, old_ptr=0, fill count=0, state=IDLE, sequencing=0, lft_out=0, rght_out=0, ovr=0. Memory contents are not reset.
- Write:
  - wrt_smpl in IDLE writes {lft_smpl,rght_smpl} to mem[new_ptr] at that edge.
  - new_ptr then increments mod DEPTH.
  - Fill count increments, saturating at READ_LEN.
- Priming:
  - A burst is triggered only by a write that leaves fill count == READ_LEN. This is the READ_LEN-th write or any later write.
  - Earlier writes only store.
- States: IDLE, LEAD, READ.
  - IDLE -> LEAD on a triggering write. Read address rd_ptr is loaded with old_ptr.
  - LEAD (1 cycle): sequencing=1. rd_ptr is presented to the synchronous RAM. Output data is stale, and the FIR clears its accumulator here.
  - READ (READ_LEN cycles): sequencing=1. lft_out/rght_out = mem[old_ptr+i] for i=0..READ_LEN-1, mod DEPTH. rd_ptr increments each cycle.
  - After the READ_LEN-th data cycle: -> IDLE, sequencing=0, and old_ptr increments by 1 mod DEPTH.
- Timing: wrt_smpl in cycle T gives
  - sequencing high from cycle T+1 through T+1+READ_LEN (READ_LEN+1 cycles total);
  - oldest sample on outputs in T+2;
  - the just-written sample on outputs in T+1+READ_LEN.
- Window: each burst replays exactly the last READ_LEN samples written, including the one that triggered it.
- Outputs outside READ hold their last value. RAM read latency is 1 cycle; output data is taken directly from the RAM read register.
- Wrap-around: all pointers wrap mod DEPTH with no special casing. The write and read ranges never overlap because READ_LEN ≤ DEPTH-1.
- Overrun:
  - wrt_smpl in LEAD or READ is dropped: no write, no pointer or count change.
  - The current burst continues unaffected.
  - ovr sets at that edge and stays set until reset.
- Simultaneous events: wrt_smpl on the same cycle the burst ends (last READ cycle) is still an overrun and is dropped. A new write is accepted from the first IDLE cycle.
- Reset mid-burst:
  - Everything returns to reset values immediately and sequencing drops asynchronously.
  - Fill count is 0, so READ_LEN new writes are needed before the next burst.
- Arithmetic: samples are passed through unmodified. There is no sign extension or scaling in this block.

Decomposition:
- Shared package `eq_pkg`: the state enum (IDLE, LEAD, READ) and the default DEPTH/READ_LEN/WIDTH constants. These are shared with the band FIR blocks so tap count and READ_LEN stay consistent.
- One sub-module, `dp_ram_sync`: a simple dual-port RAM of width 2*WIDTH and DEPTH entries, with one write port and one synchronous-read port (1-cycle latency). It is instantiated once, holding the left sample in the upper half and the right sample in the lower half.

Test Plan:
- Fill: 1020 writes, lft=k, rght=-k for k=1..1020, wrt_smpl every 64 clocks -> sequencing never asserts, outputs stay 0.
- First burst: 1021st write (k=1021) at cycle T -> sequencing high for exactly 1022 cycles starting T+1. Outputs are lft 1..1021 and rght -1..-1021 in cycles T+2..T+1022.
- Sliding window: write k=1022 -> burst replays 2..1022. After 1100 further writes, the window straddles the address-1023 -> 0 wrap and replays contiguous values with no gap or repeat.
- Overrun: wrt_smpl with value 0x7FFF at T+100 during a burst -> burst unchanged, ovr=1 from T+101 and held. The next legitimate write's burst does not contain 0x7FFF.
- Reset mid-burst: assert rst_n=0 at T+500 -> sequencing and outputs go to 0 immediately. After release, 1020 writes produce no burst and the 1021st does.
- Boundary parameters: DEPTH=8, READ_LEN=7, 20 writes -> each burst after the 7th write replays the last 7 samples in order, covering pointer wrap every 8 writes.
